// File: rtl/alu_cmd_sequencer.sv
// Tagged ALU command front-end and in-order result collector for a fixed-latency ALU.
// Latency: 2+ALU_LAT edges from command acceptance to res_valid; the FIFO stage adds one edge.
// Backpressure: issue consumes result-FIFO credits, so results are never dropped and cmd_ready falls only when the command FIFO fills.
module alu_seq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdat_i,
  output logic [W-1:0]             rdat_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign rdat_o  = mem_q[rptr_q];

  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    cnt_d = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdat_i;
  end
endmodule

module alu_cmd_sequencer #(
  parameter int WIDTH     = 32,
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int ALU_LAT   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [4:0]       cmd_shamt,
  input  logic [3:0]       cmd_tag,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [4:0]       alu_shiftValue,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_zero,
  output logic             res_sign,
  output logic [3:0]       res_tag,
  output logic             idle
);
  typedef struct packed {
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       shamt;
    logic [3:0]       tag;
  } cmd_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             carry;
    logic             zero;
    logic             sign;
    logic [3:0]       tag;
  } res_t;

  localparam int CW = $clog2(RES_DEPTH + ALU_LAT + 2) + 1;

  cmd_t                       cmd_in, cmd_head;
  logic                       cmd_full, cmd_empty;
  logic [$clog2(CMD_DEPTH):0] cmd_count;
  res_t                       res_in, res_head;
  logic                       res_full, res_empty, res_wr, res_pop;
  logic [$clog2(RES_DEPTH):0] res_count;

  logic [3:0]       alu_opcode_q, alu_opcode_d;
  logic [WIDTH-1:0] alu_input1_q, alu_input1_d;
  logic [WIDTH-1:0] alu_input2_q, alu_input2_d;
  logic [4:0]       alu_shift_q, alu_shift_d;
  logic             issue_v_q;
  logic [3:0]       issue_tag_q;
  logic [ALU_LAT-1:0] sh_v_q;
  logic [3:0]       sh_tag_q [ALU_LAT];
  logic [3:0]       sh_op_q  [ALU_LAT];

  logic [CW-1:0]    inflight, credit_used;
  logic             issue;
  logic [3:0]       last_op;

  assign cmd_in = '{opcode: cmd_opcode, a: cmd_a, b: cmd_b, shamt: cmd_shamt, tag: cmd_tag};

  alu_seq_fifo #(.W($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_valid && cmd_ready),
    .pop_i   (issue),
    .wdat_i  (cmd_in),
    .rdat_o  (cmd_head),
    .count_o (cmd_count),
    .full_o  (cmd_full),
    .empty_o (cmd_empty)
  );

  assign cmd_ready = !cmd_full;

  always_comb begin
    inflight = CW'(issue_v_q);
    for (int i = 0; i < ALU_LAT; i++) inflight = inflight + CW'(sh_v_q[i]);
  end

  // Every queued result plus every command still in the ALU holds one result-FIFO slot.
  assign res_pop     = res_valid && res_ready;
  assign credit_used = CW'(res_count) + inflight - CW'(res_pop);
  assign issue       = !cmd_empty && (credit_used < CW'(RES_DEPTH));

  always_comb begin
    alu_opcode_d = alu_opcode_q;
    alu_input1_d = alu_input1_q;
    alu_input2_d = alu_input2_q;
    alu_shift_d  = alu_shift_q;
    if (issue) begin
      alu_opcode_d = cmd_head.opcode;
      alu_input1_d = cmd_head.a;
      alu_input2_d = cmd_head.b;
      alu_shift_d  = cmd_head.shamt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_opcode_q <= '0;
      alu_input1_q <= '0;
      alu_input2_q <= '0;
      alu_shift_q  <= '0;
      issue_v_q    <= 1'b0;
      issue_tag_q  <= '0;
      sh_v_q       <= '0;
      for (int i = 0; i < ALU_LAT; i++) begin
        sh_tag_q[i] <= '0;
        sh_op_q[i]  <= '0;
      end
    end else begin
      alu_opcode_q <= alu_opcode_d;
      alu_input1_q <= alu_input1_d;
      alu_input2_q <= alu_input2_d;
      alu_shift_q  <= alu_shift_d;
      issue_v_q    <= issue;
      issue_tag_q  <= cmd_head.tag;
      sh_v_q[0]    <= issue_v_q;
      sh_tag_q[0]  <= issue_tag_q;
      sh_op_q[0]   <= alu_opcode_q;
      for (int i = 1; i < ALU_LAT; i++) begin
        sh_v_q[i]   <= sh_v_q[i-1];
        sh_tag_q[i] <= sh_tag_q[i-1];
        sh_op_q[i]  <= sh_op_q[i-1];
      end
    end
  end

  assign alu_opcode     = alu_opcode_q;
  assign alu_input1     = alu_input1_q;
  assign alu_input2     = alu_input2_q;
  assign alu_shiftValue = alu_shift_q;

  assign res_wr  = sh_v_q[ALU_LAT-1];
  assign last_op = sh_op_q[ALU_LAT-1];

  // Carry is only meaningful for ADD/SUB; other opcodes leave junk on the ALU carry.
  always_comb begin
    res_in.data  = alu_result;
    res_in.zero  = (alu_result == '0);
    res_in.sign  = alu_result[WIDTH-1];
    res_in.carry = ((last_op == 4'd0) || (last_op == 4'd1)) && alu_carry;
    res_in.tag   = sh_tag_q[ALU_LAT-1];
  end

  alu_seq_fifo #(.W($bits(res_t)), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (res_wr),
    .pop_i   (res_pop),
    .wdat_i  (res_in),
    .rdat_o  (res_head),
    .count_o (res_count),
    .full_o  (res_full),
    .empty_o (res_empty)
  );

  assign res_valid = !res_empty;
  assign res_data  = res_valid ? res_head.data  : '0;
  assign res_carry = res_valid && res_head.carry;
  assign res_zero  = res_valid && res_head.zero;
  assign res_sign  = res_valid && res_head.sign;
  assign res_tag   = res_valid ? res_head.tag   : '0;

  assign idle = (cmd_count == '0) && res_empty && (inflight == '0);

  res_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(res_wr && res_full));
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a two-stage ALU model feeds results back, and a
// scoreboard queue of hand-computed expectations is checked by an independent monitor.
module tb_alu_cmd_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [31:0] cmd_a, cmd_b;
  logic [4:0]  cmd_shamt;
  logic [3:0]  cmd_tag;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_input1, alu_input2;
  logic [4:0]  alu_shiftValue;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        res_carry, res_zero, res_sign;
  logic [3:0]  res_tag;
  logic        idle;

  typedef struct packed {
    logic [31:0] d;
    logic        c;
    logic        z;
    logic        s;
    logic [3:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.WIDTH(32), .CMD_DEPTH(4), .RES_DEPTH(4), .ALU_LAT(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_opcode     (cmd_opcode),
    .cmd_a          (cmd_a),
    .cmd_b          (cmd_b),
    .cmd_shamt      (cmd_shamt),
    .cmd_tag        (cmd_tag),
    .alu_opcode     (alu_opcode),
    .alu_input1     (alu_input1),
    .alu_input2     (alu_input2),
    .alu_shiftValue (alu_shiftValue),
    .alu_result     (alu_result),
    .alu_carry      (alu_carry),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_carry      (res_carry),
    .res_zero       (res_zero),
    .res_sign       (res_sign),
    .res_tag        (res_tag),
    .idle           (idle)
  );

  // ALU stand-in: operand capture on one edge, result on the next. Non-ADD/SUB ops drive carry=1.
  logic [3:0]  a_op_q;
  logic [31:0] a_x_q, a_y_q;
  logic [4:0]  a_sh_q;

  function automatic logic [32:0] alu_fn(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                         input logic [4:0] sh);
    case (op)
      4'd0:    alu_fn = {1'b0, x} + {1'b0, y};
      4'd1:    alu_fn = {1'b0, x} - {1'b0, y};
      4'd2:    alu_fn = {1'b1, x * y};
      4'd3:    alu_fn = {1'b1, 31'd0, ($signed(x) < $signed(y))};
      4'd5:    alu_fn = {1'b1, x << sh};
      default: alu_fn = {1'b1, x ^ y};
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      a_op_q     <= '0;
      a_x_q      <= '0;
      a_y_q      <= '0;
      a_sh_q     <= '0;
      alu_result <= '0;
      alu_carry  <= 1'b0;
    end else begin
      a_op_q <= alu_opcode;
      a_x_q  <= alu_input1;
      a_y_q  <= alu_input2;
      a_sh_q <= alu_shiftValue;
      {alu_carry, alu_result} <= alu_fn(a_op_q, a_x_q, a_y_q, a_sh_q);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic c, input logic z, input logic s, input logic [3:0] tag);
    exp_t e;
    e.d = d; e.c = c; e.z = z; e.s = s; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Presents one command, holds it until accepted, returns at the negedge after acceptance.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                      input logic [3:0] tag, input logic [31:0] ed, input logic ec, input logic ez,
                      input logic es, output int stalls);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_shamt = sh; cmd_tag = tag;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    stalls = n;
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_accept: tag %0d not accepted within %0d cycles", tag, n);
      cmd_valid = 1'b0;
    end else begin
      push_exp(ed, ec, ez, es, tag);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: compares every accepted result against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL res_unexpected: got data 0x%08h tag %0d, expected no result", res_data, res_tag);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("res_data tag%0d", e.tag), res_data, e.d);
          chk($sformatf("res_flags_tag tag%0d", e.tag),
              {25'd0, res_carry, res_zero, res_sign, res_tag}, {25'd0, e.c, e.z, e.s, e.tag});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int st, acc, stalls, n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0;
    cmd_shamt = '0; cmd_tag = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // State straight after reset
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_flags_tag", {25'd0, res_carry, res_zero, res_sign, res_tag}, 32'd0);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    chk("rst_alu_input1", alu_input1, 32'd0);
    chk("rst_alu_input2", alu_input2, 32'd0);
    chk("rst_alu_shift", 32'(alu_shiftValue), 32'd0);

    // Single ADD: latency of 4 edges, then idle again
    res_ready = 1'b1;
    send(4'd0, 32'd5, 32'd7, 5'd0, 4'd3, 32'd12, 1'b0, 1'b0, 1'b0, st);
    repeat (3) @(negedge clk);
    chk("lat_res_valid_e3", 32'(res_valid), 32'd0);
    @(negedge clk);
    chk("lat_res_valid_e4", 32'(res_valid), 32'd1);
    @(negedge clk);
    chk("idle_after_pop", 32'(idle), 32'd1);

    // Flag corner cases, back-to-back
    send(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 4'd1, 32'h0000_0000, 1'b1, 1'b1, 1'b0, st);
    send(4'd1, 32'd3, 32'd5, 5'd0, 4'd2, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, st);
    send(4'd5, 32'd1, 32'd0, 5'd31, 4'd4, 32'h8000_0000, 1'b0, 1'b0, 1'b1, st);
    send(4'd2, 32'd6, 32'd7, 5'd0, 4'd5, 32'd42, 1'b0, 1'b0, 1'b0, st);
    send(4'd3, 32'hFFFF_FFFF, 32'd1, 5'd0, 4'd6, 32'd1, 1'b0, 1'b0, 1'b0, st);
    wait_drain("flags_drain");

    // Backpressure: 4 credits plus 4 FIFO entries accepted, then cmd_ready drops
    @(negedge clk);
    res_ready = 1'b0;
    acc = 0;
    for (int t = 0; t < 16; t++) begin
      cmd_valid = 1'b1; cmd_opcode = 4'd0; cmd_a = 32'(t); cmd_b = 32'd1000;
      cmd_shamt = 5'd0; cmd_tag = 4'(t);
      if (cmd_ready) begin
        push_exp(32'(t + 1000), 1'b0, 1'b0, 1'b0, 4'(t));
        acc++;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd8);
    chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("bp_head_tag", 32'(res_tag), 32'd0);
    res_ready = 1'b1;
    wait_drain("bp_drain");

    // Full throughput: one result per cycle after the fill
    @(negedge clk);
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      send(4'd0, 32'(i * 3), 32'd1, 5'd0, 4'(i), 32'(i * 3 + 1), 1'b0, 1'b0, 1'b0, st);
      stalls += st;
    end
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("tp_stalls", 32'(stalls), 32'd0);
    chk("tp_drain_cycles", 32'(n), 32'd4);

    // Reset with three commands in flight
    @(negedge clk);
    send(4'd0, 32'd1, 32'd1, 5'd0, 4'd7, 32'd2, 1'b0, 1'b0, 1'b0, st);
    send(4'd0, 32'd2, 32'd2, 5'd0, 4'd8, 32'd4, 1'b0, 1'b0, 1'b0, st);
    send(4'd0, 32'd3, 32'd3, 5'd0, 4'd9, 32'd6, 1'b0, 1'b0, 1'b0, st);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("mid_rst_res_valid c%0d", i), 32'(res_valid), 32'd0);
      @(negedge clk);
    end
    chk("mid_rst_idle", 32'(idle), 32'd1);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    send(4'd0, 32'h10, 32'h20, 5'd0, 4'hA, 32'h30, 1'b0, 1'b0, 1'b0, st);
    wait_drain("post_rst_drain");

    repeat (3) @(negedge clk);
    chk("final_idle", 32'(idle), 32'd1);
    chk("final_res_valid", 32'(res_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
